// File: rtl/cmos_capture_param.sv
// rtl/cmos_capture_param.sv - DVP camera capture front-end with crop, frame decimation, line check and fps meter
module cmos_capture_param #(
    parameter int DIN_W         = 8,
    parameter int BYTES_PER_PIX = 2,
    parameter int CNT_W         = 12,
    parameter int WAIT_FRAMES   = 10,
    parameter int CLK_HZ        = 24_000_000,
    parameter int FPS_WIN_LOG2  = 1
) (
    input  logic                             cmos_pclk,
    input  logic                             rst_n,
    input  logic                             cmos_vsync,
    input  logic                             cmos_href,
    input  logic [DIN_W-1:0]                 cmos_din,
    input  logic                             capture_en,
    input  logic [CNT_W-1:0]                 crop_hstart,
    input  logic [CNT_W-1:0]                 crop_hstop,
    input  logic [CNT_W-1:0]                 crop_vstart,
    input  logic [CNT_W-1:0]                 crop_vstop,
    input  logic [3:0]                       decim,
    output logic [DIN_W*BYTES_PER_PIX-1:0]   pix_data,
    output logic                             pix_valid,
    output logic                             pix_sof,
    output logic                             pix_eol,
    output logic                             frame_done,
    output logic                             sync_ok,
    output logic                             line_err,
    output logic [7:0]                       fps_rate
);
    localparam int          PIX_W     = DIN_W * BYTES_PER_PIX;
    localparam logic [1:0]  BEAT_LAST = 2'(BYTES_PER_PIX - 1);
    localparam logic [31:0] WIN_LAST  = 32'((CLK_HZ << FPS_WIN_LOG2) - 1);

    typedef enum logic [1:0] {ST_SETTLE, ST_IDLE, ST_CAPT, ST_SKIP} state_t;

    state_t      state_q;
    logic [15:0] settle_q;
    logic [3:0]  skip_q;
    logic        sync_ok_q, frame_done_q;

    logic             vs_s1_q, vs_s1_d, href_s1_q, href_s1_d, vs_s2_q, vs_s2_d, href_s2_q, href_s2_d;
    logic [DIN_W-1:0] din_s1_q, din_s1_d;
    logic             vs_fall, vs_rise, href_fall, start_capt, in_window;

    logic [1:0]       beat_q, beat_d;
    logic [CNT_W-1:0] hcnt_q, hcnt_d, vcnt_q, vcnt_d;
    logic [PIX_W-1:0] shreg_q, shreg_d;
    logic [CNT_W-1:0] sh_hstart_q, sh_hstart_d, sh_hstop_q, sh_hstop_d;
    logic [CNT_W-1:0] sh_vstart_q, sh_vstart_d, sh_vstop_q, sh_vstop_d;
    logic [3:0]       sh_decim_q, sh_decim_d;
    logic             sof_pend_q, sof_pend_d;

    logic             p1_valid_q, p1_valid_d, p1_sof_q, p1_sof_d, p1_eolcol_q, p1_eolcol_d;
    logic [PIX_W-1:0] p1_data_q, p1_data_d;
    logic             pix_valid_q, pix_valid_d, pix_sof_q, pix_sof_d, pix_eol_q, pix_eol_d;
    logic [PIX_W-1:0] pix_data_q, pix_data_d;
    logic             line_err_q, line_err_d;

    logic [31:0]      win_q, win_d, fcnt_q, fcnt_d, fps_shift;
    logic [7:0]       fps_rate_q, fps_rate_d;

    assign vs_fall    = vs_s2_q & ~vs_s1_q;
    assign vs_rise    = ~vs_s2_q & vs_s1_q;
    assign href_fall  = href_s2_q & ~href_s1_q;
    assign start_capt = vs_fall & (state_q == ST_IDLE) & capture_en;

    // Pin sampling stage plus one delayed copy for edge detection
    always_comb begin
        vs_s1_d   = cmos_vsync;
        href_s1_d = cmos_href;
        din_s1_d  = cmos_din;
        vs_s2_d   = vs_s1_q;
        href_s2_d = href_s1_q;
    end

    // Window and decimation settings only change at frame start so a frame is never torn
    always_comb begin
        sh_hstart_d = sh_hstart_q;
        sh_hstop_d  = sh_hstop_q;
        sh_vstart_d = sh_vstart_q;
        sh_vstop_d  = sh_vstop_q;
        sh_decim_d  = sh_decim_q;
        if (vs_fall) begin
            sh_hstart_d = crop_hstart;
            sh_hstop_d  = crop_hstop;
            sh_vstart_d = crop_vstart;
            sh_vstop_d  = crop_vstop;
            sh_decim_d  = decim;
        end
    end

    // Beat assembly, column/row counting and the crop decision for each completed pixel
    always_comb begin
        beat_d      = beat_q;
        hcnt_d      = hcnt_q;
        vcnt_d      = vcnt_q;
        shreg_d     = shreg_q;
        sof_pend_d  = sof_pend_q | start_capt;
        p1_valid_d  = 1'b0;
        p1_sof_d    = 1'b0;
        p1_eolcol_d = 1'b0;
        p1_data_d   = p1_data_q;
        line_err_d  = href_fall & (beat_q != 2'd0);
        in_window   = (state_q == ST_CAPT)
                    && (hcnt_q >= sh_hstart_q) && (hcnt_q < sh_hstop_q)
                    && (vcnt_q >= sh_vstart_q) && (vcnt_q < sh_vstop_q);
        if (vs_fall) begin
            vcnt_d = '0;
        end else if (href_fall && vcnt_q != '1) begin
            vcnt_d = vcnt_q + CNT_W'(1);
        end
        if (href_s1_q) begin
            shreg_d = (shreg_q << DIN_W) | PIX_W'(din_s1_q);
            if (beat_q == BEAT_LAST) begin
                beat_d      = 2'd0;
                p1_valid_d  = in_window;
                p1_sof_d    = in_window & sof_pend_q;
                p1_eolcol_d = (hcnt_q == sh_hstop_q - CNT_W'(1));
                p1_data_d   = shreg_d;
                if (in_window) sof_pend_d = 1'b0;
                if (hcnt_q != '1) hcnt_d = hcnt_q + CNT_W'(1);
            end else begin
                beat_d = beat_q + 2'd1;
            end
        end else begin
            beat_d = 2'd0;
            hcnt_d = '0;
        end
    end

    // Output stage: a pixel is also end-of-line when the sample right after it shows href low
    always_comb begin
        pix_valid_d = p1_valid_q;
        pix_sof_d   = p1_valid_q & p1_sof_q;
        pix_eol_d   = p1_valid_q & (p1_eolcol_q | ~href_s1_q);
        pix_data_d  = p1_valid_q ? p1_data_q : pix_data_q;
    end

    // Frame-rate meter: vsync falls counted over a fixed window, rate latched at window end
    always_comb begin
        fps_shift  = fcnt_q >> FPS_WIN_LOG2;
        win_d      = win_q + 32'd1;
        fcnt_d     = fcnt_q + {31'd0, vs_fall};
        fps_rate_d = fps_rate_q;
        if (win_q == WIN_LAST) begin
            win_d      = '0;
            fcnt_d     = {31'd0, vs_fall};
            fps_rate_d = (fps_shift > 32'd255) ? 8'd255 : fps_shift[7:0];
        end
    end

    // Datapath registers
    always_ff @(posedge cmos_pclk or negedge rst_n) begin
        if (!rst_n) begin
            vs_s1_q <= 1'b0; href_s1_q <= 1'b0; din_s1_q <= '0; vs_s2_q <= 1'b0; href_s2_q <= 1'b0;
            beat_q <= 2'd0; hcnt_q <= '0; vcnt_q <= '0; shreg_q <= '0;
            sh_hstart_q <= '0; sh_hstop_q <= '0; sh_vstart_q <= '0; sh_vstop_q <= '0; sh_decim_q <= '0;
            sof_pend_q <= 1'b0;
            p1_valid_q <= 1'b0; p1_sof_q <= 1'b0; p1_eolcol_q <= 1'b0; p1_data_q <= '0;
            pix_valid_q <= 1'b0; pix_sof_q <= 1'b0; pix_eol_q <= 1'b0; pix_data_q <= '0;
            line_err_q <= 1'b0; win_q <= '0; fcnt_q <= '0; fps_rate_q <= '0;
        end else begin
            vs_s1_q <= vs_s1_d; href_s1_q <= href_s1_d; din_s1_q <= din_s1_d; vs_s2_q <= vs_s2_d; href_s2_q <= href_s2_d;
            beat_q <= beat_d; hcnt_q <= hcnt_d; vcnt_q <= vcnt_d; shreg_q <= shreg_d;
            sh_hstart_q <= sh_hstart_d; sh_hstop_q <= sh_hstop_d; sh_vstart_q <= sh_vstart_d;
            sh_vstop_q <= sh_vstop_d; sh_decim_q <= sh_decim_d;
            sof_pend_q <= sof_pend_d;
            p1_valid_q <= p1_valid_d; p1_sof_q <= p1_sof_d; p1_eolcol_q <= p1_eolcol_d; p1_data_q <= p1_data_d;
            pix_valid_q <= pix_valid_d; pix_sof_q <= pix_sof_d; pix_eol_q <= pix_eol_d; pix_data_q <= pix_data_d;
            line_err_q <= line_err_d; win_q <= win_d; fcnt_q <= fcnt_d; fps_rate_q <= fps_rate_d;
        end
    end

    // Frame sequencing: settle, wait for a frame start, capture, then skip decim frames
    always_ff @(posedge cmos_pclk or negedge rst_n) begin
        if (!rst_n) begin
            state_q      <= ST_SETTLE;
            settle_q     <= '0;
            skip_q       <= '0;
            sync_ok_q    <= 1'b0;
            frame_done_q <= 1'b0;
        end else begin
            frame_done_q <= 1'b0;
            case (state_q)
                ST_SETTLE: if (vs_fall) begin
                    if (settle_q + 16'd1 >= 16'(WAIT_FRAMES)) begin
                        state_q   <= ST_IDLE;
                        sync_ok_q <= 1'b1;
                    end else begin
                        settle_q <= settle_q + 16'd1;
                    end
                end
                ST_IDLE: if (start_capt) state_q <= ST_CAPT;
                ST_CAPT: if (vs_rise) begin
                    frame_done_q <= 1'b1;
                    skip_q       <= sh_decim_q;
                    state_q      <= (sh_decim_q != 4'd0) ? ST_SKIP : ST_IDLE;
                end
                ST_SKIP: if (vs_fall) begin
                    if (skip_q <= 4'd1) state_q <= ST_IDLE;
                    skip_q <= skip_q - 4'd1;
                end
                default: state_q <= ST_SETTLE;
            endcase
        end
    end

    assign pix_data   = pix_data_q;
    assign pix_valid  = pix_valid_q;
    assign pix_sof    = pix_sof_q;
    assign pix_eol    = pix_eol_q;
    assign frame_done = frame_done_q;
    assign sync_ok    = sync_ok_q;
    assign line_err   = line_err_q;
    assign fps_rate   = fps_rate_q;
endmodule

// File: tb/tb_cmos_capture_param.sv
// tb/tb_cmos_capture_param.sv - scoreboard bench for cmos_capture_param
module tb_cmos_capture_param;
    localparam int DIN_W = 8, BPP = 2, CNT_W = 12, WAIT_FRAMES = 2, CLK_HZ = 100, FPS_WIN_LOG2 = 1;
    localparam int PIX_W = DIN_W * BPP;
    localparam int WIN   = CLK_HZ << FPS_WIN_LOG2;

    logic clk = 1'b0, rst_n = 1'b0, vsync = 1'b1, href = 1'b0, capture_en = 1'b0;
    logic [DIN_W-1:0] din = '0;
    logic [CNT_W-1:0] hstart = '0, hstop = '0, vstart = '0, vstop = '0;
    logic [3:0] decim = '0;
    logic [PIX_W-1:0] pix_data;
    logic pix_valid, pix_sof, pix_eol, frame_done, sync_ok, line_err;
    logic [7:0] fps_rate;

    cmos_capture_param #(.DIN_W(DIN_W), .BYTES_PER_PIX(BPP), .CNT_W(CNT_W), .WAIT_FRAMES(WAIT_FRAMES),
                         .CLK_HZ(CLK_HZ), .FPS_WIN_LOG2(FPS_WIN_LOG2)) dut (
        .cmos_pclk(clk), .rst_n(rst_n), .cmos_vsync(vsync), .cmos_href(href), .cmos_din(din),
        .capture_en(capture_en), .crop_hstart(hstart), .crop_hstop(hstop), .crop_vstart(vstart),
        .crop_vstop(vstop), .decim(decim), .pix_data(pix_data), .pix_valid(pix_valid),
        .pix_sof(pix_sof), .pix_eol(pix_eol), .frame_done(frame_done), .sync_ok(sync_ok),
        .line_err(line_err), .fps_rate(fps_rate));

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct { logic [PIX_W-1:0] data; bit sof; bit eol; int t; } exp_t;
    exp_t sb[$];
    exp_t mon_e;

    int n_tests = 0, n_fail = 0;
    int fd_cnt = 0, le_cnt = 0, exp_fd = 0, exp_le = 0;
    int line_beats[8];

    // reference model of frame selection and the active crop window
    bit m_settled = 0, m_capt = 0, m_sof = 0;
    int m_settle_cnt = 0, m_skip = 0, m_decim = 0;
    int m_hs = 0, m_he = 0, m_vs = 0, m_ve = 0;

    task automatic check(input string name, input int act, input int req);
        n_tests++;
        if (act != req) begin
            n_fail++;
            $display("FAIL %s: actual=%0h required=%0h at cycle %0d", name, act, req, cyc);
        end
    endtask

    function automatic void model_reset();
        m_settled = 0; m_capt = 0; m_sof = 0; m_settle_cnt = 0; m_skip = 0;
    endfunction

    function automatic void model_frame_start();
        m_capt = 0;
        if (!m_settled) begin
            m_settle_cnt++;
            if (m_settle_cnt == WAIT_FRAMES) m_settled = 1;
        end else if (m_skip > 0) begin
            m_skip--;
        end else begin
            m_capt = capture_en;
        end
        m_hs = int'(hstart); m_he = int'(hstop); m_vs = int'(vstart); m_ve = int'(vstop);
        m_decim = int'(decim);
        m_sof = 1;
        if (m_capt) exp_fd++;
    endfunction

    function automatic void model_frame_end();
        if (m_capt) m_skip = m_decim;
        m_capt = 0;
    endfunction

    // monitor: every presented pixel is matched against the oldest expected one
    always @(negedge clk) begin
        if (rst_n) begin
            if (pix_valid) begin
                if (sb.size() == 0) begin
                    check("unexpected_pix", int'(pix_data), -1);
                end else begin
                    mon_e = sb.pop_front();
                    check("pix_data", int'(pix_data), int'(mon_e.data));
                    check("pix_sof", int'(pix_sof), int'(mon_e.sof));
                    check("pix_eol", int'(pix_eol), int'(mon_e.eol));
                    check("pix_latency", cyc, mon_e.t);
                end
            end
            if (line_err) le_cnt++;
            if (frame_done) fd_cnt++;
        end
    end

    task automatic set_lines(input int n, input int beats);
        for (int i = 0; i < n; i++) line_beats[i] = beats;
    endtask

    task automatic run_frame(input int nlines, input bit mid_change);
        logic [PIX_W-1:0] pix;
        exp_t e;
        int col;
        repeat (4) @(negedge clk);
        @(negedge clk); vsync = 1'b0; model_frame_start();
        repeat (3) @(negedge clk);
        for (int l = 0; l < nlines; l++) begin
            pix = '0;
            for (int b = 0; b < line_beats[l]; b++) begin
                @(negedge clk);
                href = 1'b1;
                din = DIN_W'($urandom);
                pix = (pix << DIN_W) | PIX_W'(din);
                if (b % BPP == BPP - 1) begin
                    col = b / BPP;
                    if (m_capt && col >= m_hs && col < m_he && l >= m_vs && l < m_ve) begin
                        e.data = pix; e.sof = m_sof;
                        e.eol  = (col == m_he - 1) || (b == line_beats[l] - 1);
                        e.t    = cyc + 3;
                        sb.push_back(e);
                        m_sof = 0;
                    end
                end
            end
            @(negedge clk); href = 1'b0;
            if (line_beats[l] % BPP != 0) exp_le++;
            if (mid_change && l == 0) begin
                hstart = CNT_W'($urandom_range(0, 7)); hstop = CNT_W'($urandom_range(0, 9));
                vstart = CNT_W'($urandom_range(0, 3)); vstop = CNT_W'($urandom_range(0, 4));
                decim  = 4'($urandom_range(0, 3));
            end
            repeat (2) @(negedge clk);
        end
        @(negedge clk); vsync = 1'b1; model_frame_end();
        repeat (6) @(negedge clk);
        check("frame_done_cnt", fd_cnt, exp_fd);
        check("sb_drained", sb.size(), 0);
    endtask

    task automatic set_crop(input int hs, input int he, input int vs, input int ve);
        hstart = CNT_W'(hs); hstop = CNT_W'(he); vstart = CNT_W'(vs); vstop = CNT_W'(ve);
    endtask

    task automatic settle_and_capture();
        set_crop(0, 4095, 0, 4095); decim = 4'd0; capture_en = 1'b1;
        set_lines(4, 16);
        check("sync_ok_before_settle", int'(sync_ok), 0);
        run_frame(4, 0);
        check("sync_ok_mid_settle", int'(sync_ok), 0);
        run_frame(4, 0);
        check("sync_ok_after_settle", int'(sync_ok), 1);
        run_frame(4, 0);
    endtask

    initial begin
        repeat (3) @(negedge clk);
        check("rst_pix_valid", int'(pix_valid), 0);
        check("rst_pix_data", int'(pix_data), 0);
        check("rst_sync_ok", int'(sync_ok), 0);
        check("rst_frame_done", int'(frame_done), 0);
        check("rst_fps_rate", int'(fps_rate), 0);
        rst_n = 1'b1;

        settle_and_capture();

        set_crop(2, 5, 1, 3);
        set_lines(4, 16);
        run_frame(4, 1);

        set_crop(0, 4095, 0, 4095); decim = 4'd2;
        for (int f = 0; f < 6; f++) run_frame(4, 0);

        decim = 4'd0;
        line_beats[0] = 16; line_beats[1] = 7; line_beats[2] = 16; line_beats[3] = 16;
        run_frame(4, 0);

        set_crop(3, 2, 0, 4);
        set_lines(3, 8);
        run_frame(3, 0);

        for (int f = 0; f < 14; f++) begin
            capture_en = ($urandom_range(0, 9) < 8);
            decim = 4'($urandom_range(0, 2));
            set_crop($urandom_range(0, 5), $urandom_range(0, 10), $urandom_range(0, 3), $urandom_range(0, 6));
            for (int l = 0; l < 6; l++)
                line_beats[l] = ($urandom_range(0, 3) == 0) ? int'($urandom_range(1, 19)) : 2 * int'($urandom_range(1, 10));
            run_frame($urandom_range(2, 6), 0);
        end

        capture_en = 1'b0;
        for (int p = 0; p < 3; p++) begin
            int per;
            per = (p == 0) ? 25 : (p == 1) ? 40 : 10;
            for (int c = 0; c < 700; c++) begin
                @(negedge clk);
                if ((c % per) < per / 2) begin
                    if (!vsync) model_frame_end();
                    vsync = 1'b1;
                end else begin
                    if (vsync) model_frame_start();
                    vsync = 1'b0;
                end
                if (c == 500) check("fps_rate", int'(fps_rate), (WIN / per) >> FPS_WIN_LOG2);
            end
            @(negedge clk); vsync = 1'b1; model_frame_end();
        end
        check("frame_done_fps_phase", fd_cnt, exp_fd);

        repeat (4) @(negedge clk);
        @(negedge clk); vsync = 1'b0; model_frame_start();
        repeat (3) @(negedge clk);
        for (int b = 0; b < 5; b++) begin
            @(negedge clk); href = 1'b1; din = DIN_W'($urandom);
        end
        check("sync_ok_pre_reset", int'(sync_ok), 1);
        @(negedge clk); rst_n = 1'b0; href = 1'b0; vsync = 1'b1;
        #2;
        check("midline_rst_outputs",
              int'({pix_valid, pix_sof, pix_eol, frame_done, sync_ok, line_err}), 0);
        check("midline_rst_pix_data", int'(pix_data), 0);
        check("midline_rst_fps", int'(fps_rate), 0);
        repeat (3) @(negedge clk);
        sb.delete();
        model_reset();
        rst_n = 1'b1;
        settle_and_capture();

        repeat (10) @(negedge clk);
        check("line_err_cnt", le_cnt, exp_le);
        check("final_sb_empty", sb.size(), 0);
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
